// File: rtl/axi_lite_mem_arbiter.sv
// Arbitrates the inst-fetch and data SRAM-like ports onto one AXI-Lite master,
// with a single transaction outstanding and MMU translation captured at grant.
module axi_lite_mem_arbiter #(
    parameter int DATA_PRIO = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        bus_err,
    output logic [31:0] mmu_vaddr,
    input  logic [31:0] mmu_paddr,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t      state, state_nx;
    logic [31:0] paddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        owner_q;     // 1: data port owns the transaction
    logic        last_grant;  // 1: data port won the last conflict
    logic        aw_done;
    logic        w_done;
    logic        grant_i;
    logic        grant_d;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_req && d_req) begin
                if (DATA_PRIO != 0 || !last_grant) grant_d = 1'b1;
                else                              grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_nx = d_wr ? WR_REQ : RD_ADDR;
                else if (grant_i) state_nx = RD_ADDR;
            end
            RD_ADDR: if (arready) state_nx = RD_DATA;
            RD_DATA: if (rvalid)  state_nx = IDLE;
            // AW and W complete independently; leave once both have been accepted
            WR_REQ:  if ((aw_done || awready) && (w_done || wready)) state_nx = WR_RESP;
            WR_RESP: if (bvalid)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        i_addr_ok = grant_i;
        d_addr_ok = grant_d;
        mmu_vaddr = grant_d ? d_addr : i_addr;
        araddr    = paddr_q;
        awaddr    = paddr_q;
        wdata     = wdata_q;
        wstrb     = wstrb_q;
        arvalid   = (state == RD_ADDR);
        rready    = (state == RD_DATA);
        awvalid   = (state == WR_REQ) && !aw_done;
        wvalid    = (state == WR_REQ) && !w_done;
        bready    = (state == WR_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            paddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            owner_q    <= 1'b0;
            last_grant <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            i_data_ok  <= 1'b0;
            d_data_ok  <= 1'b0;
            bus_err    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state     <= state_nx;
            i_data_ok <= 1'b0;
            d_data_ok <= 1'b0;
            bus_err   <= 1'b0;

            if (grant_i || grant_d) begin
                paddr_q <= mmu_paddr;
                wdata_q <= d_wdata;
                wstrb_q <= d_wstrb;
                owner_q <= grant_d;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == IDLE && i_req && d_req) last_grant <= grant_d;

            if (state == WR_REQ) begin
                if (awready) aw_done <= 1'b1;
                if (wready)  w_done  <= 1'b1;
            end

            if (state == RD_DATA && rvalid) begin
                if (owner_q) begin
                    d_rdata   <= rdata;
                    d_data_ok <= 1'b1;
                end else begin
                    i_rdata   <= rdata;
                    i_data_ok <= 1'b1;
                end
                bus_err <= (rresp != 2'b00);
            end

            if (state == WR_RESP && bvalid) begin
                d_data_ok <= 1'b1;
                bus_err   <= (bresp != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed bench for axi_lite_mem_arbiter: round-robin instance with a
// configurable-latency slave, plus a data-priority instance on an always-ready slave.
module tb_axi_lite_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // round-robin instance
    logic        i_req, i_addr_ok, i_data_ok;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_wr, d_addr_ok, d_data_ok, bus_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic [31:0] mmu_vaddr, mmu_paddr;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    // data-priority instance
    logic        p_i_req, p_d_req, p_i_addr_ok, p_d_addr_ok, p_i_data_ok, p_d_data_ok, p_bus_err;
    logic [31:0] p_i_addr, p_d_addr, p_i_rdata, p_d_rdata, p_vaddr, p_araddr, p_awaddr, p_wdata;
    logic        p_arvalid, p_rready, p_awvalid, p_wvalid, p_bready;
    logic [3:0]  p_wstrb;

    assign mmu_paddr = mmu_vaddr & 32'h1FFF_FFFF;

    axi_lite_mem_arbiter #(.DATA_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata), .bus_err(bus_err),
        .mmu_vaddr(mmu_vaddr), .mmu_paddr(mmu_paddr),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axi_lite_mem_arbiter #(.DATA_PRIO(1)) dut_prio (
        .clk(clk), .reset(reset),
        .i_req(p_i_req), .i_addr(p_i_addr), .i_addr_ok(p_i_addr_ok), .i_data_ok(p_i_data_ok), .i_rdata(p_i_rdata),
        .d_req(p_d_req), .d_wr(1'b0), .d_addr(p_d_addr), .d_wdata(32'h0), .d_wstrb(4'h0),
        .d_addr_ok(p_d_addr_ok), .d_data_ok(p_d_data_ok), .d_rdata(p_d_rdata), .bus_err(p_bus_err),
        .mmu_vaddr(p_vaddr), .mmu_paddr(p_vaddr),
        .araddr(p_araddr), .arvalid(p_arvalid), .arready(1'b1),
        .rdata(32'h0), .rresp(2'b00), .rvalid(1'b1), .rready(p_rready),
        .awaddr(p_awaddr), .awvalid(p_awvalid), .awready(1'b1),
        .wdata(p_wdata), .wstrb(p_wstrb), .wvalid(p_wvalid), .wready(1'b1),
        .bresp(2'b00), .bvalid(1'b1), .bready(p_bready)
    );

    // slave model: each ready/valid asserts after a configurable number of wait cycles
    int unsigned ar_wait, aw_wait, w_wait, r_wait, b_wait;
    int unsigned ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    logic [31:0] rdata_val, ar_seen, aw_seen, w_seen;
    logic [3:0]  ws_seen;
    logic [1:0]  rresp_val, bresp_val;
    logic        r_pend, aw_got, w_got;

    assign arready = arvalid && (ar_cnt >= ar_wait);
    assign awready = awvalid && (aw_cnt >= aw_wait);
    assign wready  = wvalid && (w_cnt >= w_wait);
    assign rvalid  = r_pend && (r_cnt >= r_wait);
    assign bvalid  = aw_got && w_got && (b_cnt >= b_wait);
    assign rdata   = rdata_val;
    assign rresp   = rresp_val;
    assign bresp   = bresp_val;

    always @(posedge clk) begin
        if (reset) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            ar_seen <= '0; aw_seen <= '0; w_seen <= '0; ws_seen <= '0;
        end else begin
            if (arvalid && !arready) ar_cnt <= ar_cnt + 1;
            if (arvalid && arready) begin
                ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= 0; ar_seen <= araddr;
            end
            if (r_pend && !rvalid) r_cnt <= r_cnt + 1;
            if (rvalid && rready) r_pend <= 1'b0;
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            if (awvalid && awready) begin
                aw_cnt <= 0; aw_got <= 1'b1; aw_seen <= awaddr;
            end
            if (wvalid && !wready) w_cnt <= w_cnt + 1;
            if (wvalid && wready) begin
                w_cnt <= 0; w_got <= 1'b1; w_seen <= wdata; ws_seen <= wstrb;
            end
            if (aw_got && w_got && !bvalid) b_cnt <= b_cnt + 1;
            if (bvalid && bready) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
            fails++; $display("FAIL reset_axi_ctrl: got %b exp 00000", {arvalid, rready, awvalid, wvalid, bready});
        end
        tests++;
        if ({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, bus_err} !== 5'b0) begin
            fails++; $display("FAIL reset_req_ctrl: got %b exp 00000", {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, bus_err});
        end
        tests++;
        if ({i_rdata, d_rdata, araddr, awaddr} !== 128'h0) begin
            fails++; $display("FAIL reset_regs: got %h exp 0", {i_rdata, d_rdata, araddr, awaddr});
        end
        next_cycle;
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({arvalid, awvalid, i_addr_ok, d_addr_ok} !== 4'b0) begin
            fails++; $display("FAIL idle_after_reset: got %b exp 0000", {arvalid, awvalid, i_addr_ok, d_addr_ok});
        end
        next_cycle;
    endtask

    task automatic test_inst_read;
        rdata_val = 32'h2400_0001;
        i_req = 1'b1; i_addr = 32'hBFC0_0000;
        @(negedge clk);
        tests++;
        if ({i_addr_ok, d_addr_ok} !== 2'b10 || mmu_vaddr !== 32'hBFC0_0000) begin
            fails++; $display("FAIL inst_grant: got ok=%b vaddr=%h exp ok=10 vaddr=bfc00000", {i_addr_ok, d_addr_ok}, mmu_vaddr);
        end
        next_cycle;
        i_req = 1'b0; i_addr = 32'h0;
        @(negedge clk);
        tests++;
        if (arvalid !== 1'b1 || araddr !== 32'h1FC0_0000) begin
            fails++; $display("FAIL inst_ar: got arvalid=%b araddr=%h exp 1 1fc00000", arvalid, araddr);
        end
        next_cycle;
        @(negedge clk);
        tests++;
        if ({arvalid, rready, i_data_ok} !== 3'b010) begin
            fails++; $display("FAIL inst_r_phase: got %b exp 010", {arvalid, rready, i_data_ok});
        end
        next_cycle;
        @(negedge clk);
        tests++;
        if ({i_data_ok, d_data_ok, bus_err} !== 3'b100 || i_rdata !== 32'h2400_0001) begin
            fails++; $display("FAIL inst_data_ok: got ok/err=%b rdata=%h exp 100 24000001", {i_data_ok, d_data_ok, bus_err}, i_rdata);
        end
        next_cycle;
        @(negedge clk);
        tests++;
        if (i_data_ok !== 1'b0 || ar_seen !== 32'h1FC0_0000) begin
            fails++; $display("FAIL inst_pulse: got data_ok=%b ar_seen=%h exp 0 1fc00000", i_data_ok, ar_seen);
        end
        next_cycle;
    endtask

    task automatic test_write;
        int pulses;
        aw_wait = 0; w_wait = 2;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h8000_0010; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        @(negedge clk);
        tests++;
        if (d_addr_ok !== 1'b1 || mmu_vaddr !== 32'h8000_0010) begin
            fails++; $display("FAIL wr_grant: got ok=%b vaddr=%h exp 1 80000010", d_addr_ok, mmu_vaddr);
        end
        next_cycle;
        d_req = 1'b0; d_wr = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0;
        @(negedge clk);
        tests++;
        if ({awvalid, wvalid, awready, wready} !== 4'b1110 || awaddr !== 32'h10 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'b0011) begin
            fails++; $display("FAIL wr_first: got v/r=%b awaddr=%h wdata=%h wstrb=%b exp 1110 10 deadbeef 0011",
                              {awvalid, wvalid, awready, wready}, awaddr, wdata, wstrb);
        end
        next_cycle;
        @(negedge clk);
        tests++;
        if ({awvalid, wvalid, wready} !== 3'b010) begin
            fails++; $display("FAIL wr_w_held: got %b exp 010", {awvalid, wvalid, wready});
        end
        next_cycle;
        @(negedge clk);
        tests++;
        if ({awvalid, wvalid, wready, bready} !== 4'b0110) begin
            fails++; $display("FAIL wr_w_hs: got %b exp 0110", {awvalid, wvalid, wready, bready});
        end
        next_cycle;
        @(negedge clk);
        tests++;
        if ({wvalid, bready, bvalid, d_data_ok} !== 4'b0110) begin
            fails++; $display("FAIL wr_b_phase: got %b exp 0110", {wvalid, bready, bvalid, d_data_ok});
        end
        next_cycle;
        @(negedge clk);
        tests++;
        if ({d_data_ok, i_data_ok, bus_err, bready} !== 4'b1000) begin
            fails++; $display("FAIL wr_data_ok: got %b exp 1000", {d_data_ok, i_data_ok, bus_err, bready});
        end
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            next_cycle;
            @(negedge clk);
            if (d_data_ok) pulses++;
        end
        tests++;
        if (pulses !== 0 || w_seen !== 32'hDEAD_BEEF || ws_seen !== 4'b0011 || aw_seen !== 32'h10) begin
            fails++; $display("FAIL wr_single: got extra=%0d w=%h s=%b aw=%h exp 0 deadbeef 0011 10", pulses, w_seen, ws_seen, aw_seen);
        end
        w_wait = 0;
        next_cycle;
    endtask

    task automatic test_bus_err;
        rdata_val = 32'h0000_1234; rresp_val = 2'b10;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h8000_1000;
        @(negedge clk);
        tests++;
        if (d_addr_ok !== 1'b1) begin
            fails++; $display("FAIL err_grant: got %b exp 1", d_addr_ok);
        end
        next_cycle;
        d_req = 1'b0;
        repeat (2) next_cycle;
        @(negedge clk);
        tests++;
        if ({d_data_ok, bus_err, i_data_ok} !== 3'b110 || d_rdata !== 32'h1234) begin
            fails++; $display("FAIL err_data_ok: got ok/err=%b rdata=%h exp 110 00001234", {d_data_ok, bus_err, i_data_ok}, d_rdata);
        end
        next_cycle;
        @(negedge clk);
        tests++;
        if ({d_data_ok, bus_err, arvalid, rready} !== 4'b0 || i_rdata !== 32'h2400_0001) begin
            fails++; $display("FAIL err_idle: got %b i_rdata=%h exp 0000 24000001", {d_data_ok, bus_err, arvalid, rready}, i_rdata);
        end
        rresp_val = 2'b00;
        next_cycle;
    endtask

    task automatic test_round_robin;
        int   ngrant, both;
        logic [3:0] exp_d;
        exp_d = 4'b0101;
        ngrant = 0; both = 0;
        i_req = 1'b1; i_addr = 32'h9FC0_0100;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h8000_0200;
        for (int c = 0; c < 40 && ngrant < 4; c++) begin
            @(negedge clk);
            if (i_addr_ok && d_addr_ok) both++;
            if (i_addr_ok || d_addr_ok) begin
                tests++;
                if (d_addr_ok !== exp_d[ngrant] || mmu_vaddr !== (exp_d[ngrant] ? 32'h8000_0200 : 32'h9FC0_0100)) begin
                    fails++; $display("FAIL rr_grant%0d: got data=%b vaddr=%h exp data=%b", ngrant, d_addr_ok, mmu_vaddr, exp_d[ngrant]);
                end
                ngrant++;
            end
            next_cycle;
        end
        i_req = 1'b0; d_req = 1'b0;
        tests++;
        if (ngrant !== 4 || both !== 0) begin
            fails++; $display("FAIL rr_count: got grants=%0d dual=%0d exp 4 0", ngrant, both);
        end
        repeat (6) next_cycle;
    endtask

    task automatic test_data_prio;
        int   ngrant;
        logic [4:0] exp_d;
        exp_d = 5'b01111;
        ngrant = 0;
        p_i_req = 1'b1; p_i_addr = 32'h0000_0400;
        p_d_req = 1'b1; p_d_addr = 32'h0000_0800;
        for (int c = 0; c < 60 && ngrant < 5; c++) begin
            @(negedge clk);
            if (p_i_addr_ok || p_d_addr_ok) begin
                tests++;
                if ({p_i_addr_ok, p_d_addr_ok} !== {~exp_d[ngrant], exp_d[ngrant]}) begin
                    fails++; $display("FAIL prio_grant%0d: got i/d=%b exp data=%b", ngrant, {p_i_addr_ok, p_d_addr_ok}, exp_d[ngrant]);
                end
                ngrant++;
            end
            next_cycle;
            if (ngrant == 4) p_d_req = 1'b0;
        end
        p_i_req = 1'b0; p_d_req = 1'b0;
        tests++;
        if (ngrant !== 5) begin
            fails++; $display("FAIL prio_count: got %0d exp 5", ngrant);
        end
        repeat (6) next_cycle;
    endtask

    task automatic test_reset_mid;
        int pulses;
        r_wait = 5;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h8000_2000;
        @(negedge clk);
        next_cycle;
        d_req = 1'b0;
        @(negedge clk);
        tests++;
        if (arvalid !== 1'b1 || araddr !== 32'h2000) begin
            fails++; $display("FAIL mid_ar: got %b %h exp 1 00002000", arvalid, araddr);
        end
        next_cycle;
        @(negedge clk);
        tests++;
        if ({rready, rvalid} !== 2'b10) begin
            fails++; $display("FAIL mid_rd_data: got %b exp 10", {rready, rvalid});
        end
        next_cycle;
        reset = 1'b1;
        next_cycle;
        @(negedge clk);
        tests++;
        if ({arvalid, rready, d_data_ok, i_data_ok} !== 4'b0 || d_rdata !== 32'h0 || i_rdata !== 32'h0) begin
            fails++; $display("FAIL mid_abort: got %b d=%h i=%h exp 0000 0 0", {arvalid, rready, d_data_ok, i_data_ok}, d_rdata, i_rdata);
        end
        next_cycle;
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (d_data_ok || i_data_ok || rready || arvalid) pulses++;
            next_cycle;
        end
        tests++;
        if (pulses !== 0) begin
            fails++; $display("FAIL mid_quiet: got %0d active cycles exp 0", pulses);
        end
        r_wait = 0;
    endtask

    task automatic test_back_to_back;
        rdata_val = 32'h1111_1111;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h8000_3000;
        @(negedge clk);
        tests++;
        if (d_addr_ok !== 1'b1) begin
            fails++; $display("FAIL b2b_grant1: got %b exp 1", d_addr_ok);
        end
        next_cycle;
        d_addr = 32'h8000_3004;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests++;
            if ({d_addr_ok, i_addr_ok} !== 2'b00) begin
                fails++; $display("FAIL b2b_busy%0d: got %b exp 00", k, {d_addr_ok, i_addr_ok});
            end
            next_cycle;
        end
        rdata_val = 32'h2222_2222;
        @(negedge clk);
        tests++;
        if ({d_data_ok, d_addr_ok} !== 2'b11 || d_rdata !== 32'h1111_1111 || mmu_vaddr !== 32'h8000_3004) begin
            fails++; $display("FAIL b2b_overlap: got ok=%b rdata=%h vaddr=%h exp 11 11111111 80003004", {d_data_ok, d_addr_ok}, d_rdata, mmu_vaddr);
        end
        next_cycle;
        d_req = 1'b0;
        @(negedge clk);
        tests++;
        if (arvalid !== 1'b1 || araddr !== 32'h3004) begin
            fails++; $display("FAIL b2b_ar2: got %b %h exp 1 00003004", arvalid, araddr);
        end
        repeat (2) next_cycle;
        @(negedge clk);
        tests++;
        if (d_data_ok !== 1'b1 || d_rdata !== 32'h2222_2222) begin
            fails++; $display("FAIL b2b_data2: got %b %h exp 1 22222222", d_data_ok, d_rdata);
        end
        next_cycle;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        p_i_req = 1'b0; p_d_req = 1'b0; p_i_addr = '0; p_d_addr = '0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0; b_wait = 0;
        rdata_val = '0; rresp_val = 2'b00; bresp_val = 2'b00;
        test_reset;
        test_inst_read;
        test_write;
        test_bus_err;
        test_round_robin;
        test_data_prio;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
